// File: rtl/alarm_snooze_ctrl.sv
// Alarm output sequencer: arm on time match, ring, snooze, auto-stop.
// Ports: clk, reset, AL_ON, STOP_al, SNOOZE, time_match -> Alarm, snoozing, snooze_cnt.
module alarm_snooze_ctrl #(
  parameter int TICKS_PER_SEC = 10,
  parameter int RING_MAX_S    = 60,
  parameter int SNOOZE_S      = 300,
  parameter int MAX_SNOOZE    = 3,
  parameter int SCW           = $clog2(MAX_SNOOZE + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           AL_ON,
  input  logic           STOP_al,
  input  logic           SNOOZE,
  input  logic           time_match,
  output logic           Alarm,
  output logic           snoozing,
  output logic [SCW-1:0] snooze_cnt
);

  localparam int SMAX = (RING_MAX_S > SNOOZE_S) ? RING_MAX_S : SNOOZE_S;
  localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
  localparam int TW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [SCW-1:0]  cnt_n;
  logic [TW-1:0]   tick_cnt;
  logic [SW-1:0]   sec_cnt;
  logic            tm_q, snz_q;
  logic            tm_hold, snz_hold;
  logic            match_rise, snz_rise;
  logic            tick_wrap;
  logic            alarm_n, snoozing_n;

  // The hold flops remember a level present during reset so it
  // does not look like a fresh edge on the first cycle afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      tm_q     <= 1'b0;
      snz_q    <= 1'b0;
      tm_hold  <= time_match;
      snz_hold <= SNOOZE;
    end else begin
      tm_q     <= time_match;
      snz_q    <= SNOOZE;
      tm_hold  <= 1'b0;
      snz_hold <= 1'b0;
    end
  end

  assign match_rise = time_match & ~tm_q & ~tm_hold;
  assign snz_rise   = SNOOZE & ~snz_q & ~snz_hold;
  assign tick_wrap  = (tick_cnt == TW'(TICKS_PER_SEC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      snooze_cnt <= '0;
      Alarm      <= 1'b0;
      snoozing   <= 1'b0;
    end else begin
      state      <= state_n;
      snooze_cnt <= cnt_n;
      Alarm      <= alarm_n;
      snoozing   <= snoozing_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = snooze_cnt;
    unique case (state)
      IDLE: begin
        if (AL_ON & match_rise & ~STOP_al)
          state_n = RINGING;
      end
      RINGING: begin
        if (~AL_ON | STOP_al) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (snz_rise &&
                     snooze_cnt < SCW'(MAX_SNOOZE)) begin
          state_n = SNOOZED;
          cnt_n   = snooze_cnt + SCW'(1);
        end else if (tick_wrap &&
                     sec_cnt == SW'(RING_MAX_S - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      SNOOZED: begin
        if (~AL_ON | STOP_al) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (tick_wrap &&
                     sec_cnt == SW'(SNOOZE_S - 1)) begin
          state_n = RINGING;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered.
  always_comb begin
    alarm_n    = (state_n == RINGING);
    snoozing_n = (state_n == SNOOZED);
  end

  // Timers restart on every transition and rest at 0 in IDLE.
  always_ff @(posedge clk) begin
    if (reset || state_n != state || state == IDLE) begin
      tick_cnt <= '0;
      sec_cnt  <= '0;
    end else if (tick_wrap) begin
      tick_cnt <= '0;
      sec_cnt  <= sec_cnt + SW'(1);
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Testbench for alarm_snooze_ctrl: vector table, directed sequences,
// and random stimulus against a cycle-count reference model.
module tb_alarm_snooze_ctrl;

  localparam int TPS  = 10;
  localparam int RING = 3;
  localparam int SNZ  = 2;
  localparam int MAXS = 2;
  localparam int SCW  = $clog2(MAXS + 1);

  logic           clk = 1'b0;
  logic           reset, AL_ON, STOP_al, SNOOZE, time_match;
  logic           Alarm, snoozing;
  logic [SCW-1:0] snooze_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: mode 0 idle, 1 ringing, 2 snoozed.
  int m_mode = 0;
  int m_el   = 0;
  int m_cnt  = 0;
  bit m_ptm  = 0;
  bit m_psn  = 0;

  always #5 clk = ~clk;

  alarm_snooze_ctrl #(
    .TICKS_PER_SEC(TPS),
    .RING_MAX_S   (RING),
    .SNOOZE_S     (SNZ),
    .MAX_SNOOZE   (MAXS),
    .SCW          (SCW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .AL_ON     (AL_ON),
    .STOP_al   (STOP_al),
    .SNOOZE    (SNOOZE),
    .time_match(time_match),
    .Alarm     (Alarm),
    .snoozing  (snoozing),
    .snooze_cnt(snooze_cnt)
  );

  typedef struct {
    bit r, al, st, sn, tm;
    bit ea, es;
    int ec;
  } vec_t;

  vec_t vt[16];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: counts cycles spent in the current mode.
  task automatic model_step(input bit r, al, st, sn, tm);
    bit mr, sr;
    if (r) begin
      m_mode = 0; m_el = 0; m_cnt = 0;
      m_ptm = tm; m_psn = sn;
      return;
    end
    mr = tm & ~m_ptm;
    sr = sn & ~m_psn;
    m_ptm = tm; m_psn = sn;
    case (m_mode)
      0: if (al && mr && !st) begin m_mode = 1; m_el = 0; end
      1: begin
        if (!al || st) begin m_mode = 0; m_cnt = 0; end
        else if (sr && m_cnt < MAXS) begin
          m_mode = 2; m_cnt++; m_el = 0;
        end else if (m_el + 1 == RING * TPS) begin
          m_mode = 0; m_cnt = 0;
        end else m_el++;
      end
      default: begin
        if (!al || st) begin m_mode = 0; m_cnt = 0; end
        else if (m_el + 1 == SNZ * TPS) begin
          m_mode = 1; m_el = 0;
        end else m_el++;
      end
    endcase
  endtask

  task automatic step(input bit r, al, st, sn, tm);
    reset = r; AL_ON = al; STOP_al = st;
    SNOOZE = sn; time_match = tm;
    @(posedge clk);
    #1;
    model_step(r, al, st, sn, tm);
  endtask

  task automatic idle1(); step(0, AL_ON, 0, SNOOZE, time_match); endtask

  initial begin
    int ring_len, snz_len, lim;
    reset = 1; AL_ON = 0; STOP_al = 0; SNOOZE = 0; time_match = 0;

    // Test 1: auto-stop after RING*TPS cycles.
    step(1, 1, 0, 0, 0);
    check("reset_alarm", Alarm, 0);
    check("reset_snoozing", snoozing, 0);
    check("reset_cnt", snooze_cnt, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    check("arm_alarm", Alarm, 1);
    ring_len = 1;
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 60 && Alarm; i++) begin
      ring_len++;
      step(0, 1, 0, 0, 0);
    end
    check("ring_len", ring_len, RING * TPS);
    check("autostop_alarm", Alarm, 0);
    check("autostop_cnt", snooze_cnt, 0);

    // Test 2: snooze on ring cycle 4.
    step(0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    check("pre_snz_alarm", Alarm, 1);
    step(0, 1, 0, 1, 0);
    check("snz_alarm", Alarm, 0);
    check("snz_flag", snoozing, 1);
    check("snz_cnt1", snooze_cnt, 1);
    snz_len = 1;
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 60 && snoozing; i++) begin
      snz_len++;
      step(0, 1, 0, 0, 0);
    end
    check("snz_len", snz_len, SNZ * TPS);
    check("rering_alarm", Alarm, 1);
    check("rering_cnt", snooze_cnt, 1);

    // Test 3: second snooze allowed, third ignored.
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    check("snz2_cnt", snooze_cnt, 2);
    for (int i = 0; i < 60 && snoozing; i++) step(0, 1, 0, 0, 0);
    check("rering2_alarm", Alarm, 1);
    step(0, 1, 0, 1, 0);
    check("snz3_alarm", Alarm, 1);
    check("snz3_flag", snoozing, 0);
    check("snz3_cnt", snooze_cnt, 2);
    lim = 0;
    while (Alarm && lim < 60) begin
      step(0, 1, 0, 0, 0);
      lim++;
    end
    check("limit_autostop", Alarm, 0);
    check("limit_cnt_clr", snooze_cnt, 0);

    // Tests 4-6 as a vector table.
    //        r  al st sn tm  ea es ec
    vt[0]  = '{1, 1, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{0, 1, 0, 0, 1, 1, 0, 0};
    vt[2]  = '{0, 1, 0, 0, 1, 1, 0, 0};
    vt[3]  = '{0, 1, 1, 1, 1, 0, 0, 0};
    vt[4]  = '{0, 1, 0, 0, 1, 0, 0, 0};
    vt[5]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    vt[6]  = '{0, 0, 0, 0, 1, 0, 0, 0};
    vt[7]  = '{0, 1, 0, 0, 1, 0, 0, 0};
    vt[8]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    vt[9]  = '{0, 1, 0, 0, 1, 1, 0, 0};
    vt[10] = '{0, 1, 0, 1, 1, 0, 1, 1};
    vt[11] = '{0, 1, 0, 0, 1, 0, 1, 1};
    vt[12] = '{1, 1, 0, 1, 1, 0, 0, 0};
    vt[13] = '{0, 1, 0, 1, 1, 0, 0, 0};
    vt[14] = '{0, 1, 0, 0, 0, 0, 0, 0};
    vt[15] = '{0, 1, 0, 0, 1, 1, 0, 0};
    for (int i = 0; i < 16; i++) begin
      step(vt[i].r, vt[i].al, vt[i].st, vt[i].sn, vt[i].tm);
      check($sformatf("vec%0d_alarm", i), Alarm, vt[i].ea);
      check($sformatf("vec%0d_snoozing", i), snoozing, vt[i].es);
      check($sformatf("vec%0d_cnt", i), snooze_cnt, vt[i].ec);
    end

    // Random stimulus against the model.
    step(1, 0, 0, 0, 0);
    begin
      bit r, al, st, sn, tm;
      sn = 0; tm = 0;
      for (int i = 0; i < 4000; i++) begin
        r  = ($urandom_range(199) == 0);
        al = ($urandom_range(31) != 0);
        st = ($urandom_range(59) == 0);
        if ($urandom_range(7) == 0) sn = ~sn;
        if ($urandom_range(11) == 0) tm = ~tm;
        step(r, al, st, sn, tm);
        check("rnd_alarm", Alarm, (m_mode == 1) ? 1 : 0);
        check("rnd_snoozing", snoozing, (m_mode == 2) ? 1 : 0);
        check("rnd_cnt", snooze_cnt, m_cnt);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
